fetch_ctrl: RTL and testbench

// - Sequences the fetch stage: owns the PC register and drives the instruction bus.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 29 ++
 rtl/fetch_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch-stage types, reset PC and ibus request/response structs
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
  localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] FETCH_PC_STEP = 32'd4;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } ibus_rsp_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch PC plus a pending redirect target parked while a request awaits addr_ok
module fetch_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] PC_STEP = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_pc,
  input  logic        ld_pend,
  input  logic        take_pend,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        pend
);
  logic [31:0] pend_pc;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pc <= RESET_PC;
      pend <= 1'b0;
      pend_pc <= '0;
    end else begin
      pc <= ld_pc ? target : (take_pend && pend) ? pend_pc : inc ? pc + PC_STEP : pc;
      pend <= ld_pend || (pend && !take_pend);
      if (ld_pend) pend_pc <= target;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer; single-outstanding ibus handshake feeding a one-entry decode buffer
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] PC_STEP = FETCH_PC_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_adel
);
  fetch_state_t state, nxt;
  logic [31:0] pc;
  logic pend, discard, nxt_discard, stray_ok, misal, accept;
  logic ld_pc, ld_pend, take_pend, inc, buf_load, buf_adel, buf_clr;
  ibus_req_t req;
  ibus_rsp_t rsp;
  assign rsp = '{addr_ok: addr_ok, data_ok: data_ok, rdata: rdata};
  assign misal = |pc[1:0];
  assign accept = inst_valid && !stall;
  assign req = '{valid: resetn && state == REQ && !misal, addr: pc};
  assign ireq_valid = req.valid;
  assign ireq_addr = req.addr;
  fetch_pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk(clk), .resetn(resetn), .ld_pc(ld_pc), .ld_pend(ld_pend), .take_pend(take_pend),
    .inc(inc), .target(redirect_pc), .pc(pc), .pend(pend)
  );
  // A redirect during an unaccepted request is parked so ireq_addr stays stable.
  always_comb begin
    nxt = state;
    nxt_discard = discard;
    ld_pc = 1'b0;
    ld_pend = 1'b0;
    take_pend = 1'b0;
    inc = 1'b0;
    buf_load = 1'b0;
    buf_adel = 1'b0;
    buf_clr = 1'b0;
    case (state)
      REQ:
        if (redirect_valid && (misal || !rsp.addr_ok)) begin
          ld_pc = misal;
          ld_pend = !misal;
        end else if (misal) begin
          buf_adel = 1'b1;
          nxt = HOLD;
        end else if (rsp.addr_ok) begin
          take_pend = 1'b1;
          ld_pc = redirect_valid;
          nxt_discard = pend || redirect_valid;
          nxt = WAIT;
        end
      WAIT:
        if (redirect_valid) begin
          ld_pc = 1'b1;
          nxt_discard = !rsp.data_ok;
          nxt = rsp.data_ok ? REQ : WAIT;
        end else if (rsp.data_ok) begin
          nxt_discard = 1'b0;
          buf_load = !discard;
          inc = !discard;
          nxt = discard ? REQ : HOLD;
        end
      HOLD:
        if (redirect_valid || accept) begin
          ld_pc = redirect_valid;
          buf_clr = 1'b1;
          nxt = REQ;
        end
      default: nxt = REQ;
    endcase
  end
  // stray_ok tolerates one response still in flight from before a reset.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= REQ;
      discard <= 1'b0;
      stray_ok <= 1'b1;
      inst_valid <= 1'b0;
      inst <= '0;
      inst_pc <= '0;
      inst_adel <= 1'b0;
    end else begin
      state <= nxt;
      discard <= nxt_discard;
      if (rsp.addr_ok || rsp.data_ok) stray_ok <= 1'b0;
      if (buf_load || buf_adel) begin
        inst_valid <= 1'b1;
        inst <= buf_load ? rsp.rdata : '0;
        inst_pc <= pc;
        inst_adel <= buf_adel;
      end else if (buf_clr) inst_valid <= 1'b0;
    end
  a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!resetn)
    data_ok |-> (state == WAIT || stray_ok));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized bus/stall/redirect traffic checked against a fetch-stream scoreboard
module tb_fetch_ctrl;
  logic clk = 1'b0, resetn = 1'b0, redirect_valid = 1'b0, stall = 1'b0, addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] redirect_pc = '0, rdata = '0;
  logic ireq_valid, inst_valid, inst_adel;
  logic [31:0] ireq_addr, inst, inst_pc;
  int errors = 0, checks = 0;
  logic busy = 1'b0;
  logic [31:0] b_addr = '0;
  int d_cnt = 0, ok_delay = 0, ok_gap = 0, data_lat = 0;
  bit rnd_bus = 1'b0;
  logic s_iv, s_v, s_adel, acc, dlv;
  logic [31:0] s_ia, s_i, s_pc;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One clock: sample outputs at negedge, act as ibus slave and decode, then take the edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    s_iv = ireq_valid; s_ia = ireq_addr; s_v = inst_valid; s_i = inst; s_pc = inst_pc; s_adel = inst_adel;
    acc = s_iv && ok_delay == 0;
    if (s_iv && ok_delay > 0) ok_delay--;
    addr_ok = acc;
    data_ok = busy && d_cnt == 0;
    rdata = data_ok ? mem(b_addr) : $urandom;
    stall = st; redirect_valid = rv; redirect_pc = rp;
    dlv = s_v && !st && !rv;
    @(posedge clk);
    if (data_ok) busy = 1'b0;
    else if (busy) d_cnt--;
    if (acc) begin
      busy = 1'b1; b_addr = s_ia;
      d_cnt = rnd_bus ? int'($urandom_range(0, 2)) : data_lat;
      ok_delay = rnd_bus ? int'($urandom_range(0, 2)) : ok_gap;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    busy = 1'b0; ok_delay = ok_gap;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ireq_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_adel !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got iv=%b v=%b inst=%h pc=%h adel=%b want all zero", ireq_valid, inst_valid, inst, inst_pc, inst_adel);
    end
    resetn = 1'b1;
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (s_iv !== 1'b1 || s_ia !== 32'hbfc0_0000) begin
      errors++; $display("FAIL reset_first_req: got iv=%b addr=%h want 1 bfc00000", s_iv, s_ia);
    end
  endtask

  task automatic test_seq();
    logic [31:0] e;
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 1'b0, '0);
      e = 32'hbfc0_0000 + 32'(4 * (k / 3));
      checks++;
      if (acc !== (k % 3 == 0) || (acc && s_ia !== e)) begin
        errors++; $display("FAIL seq_req k=%0d: got acc=%b addr=%h want acc=%b addr=%h", k, acc, s_ia, k % 3 == 0, e);
      end
      checks++;
      if (dlv !== (k % 3 == 2) || (dlv && (s_pc !== e || s_i !== mem(e) || s_adel !== 1'b0))) begin
        errors++; $display("FAIL seq_inst k=%0d: got dlv=%b pc=%h inst=%h want dlv=%b pc=%h inst=%h", k, dlv, s_pc, s_i, k % 3 == 2, e, mem(e));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_i, h_pc;
    int n;
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    do_reset();
    n = 0;
    do begin cycle(1'b1, 1'b0, '0); n++; end while (!s_v && n < 10);
    checks++;
    if (s_v !== 1'b1) begin errors++; $display("FAIL stall_reach: got inst_valid=%b want 1", s_v); end
    h_i = s_i; h_pc = s_pc;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, '0);
      checks++;
      if (s_v !== 1'b1 || s_i !== h_i || s_pc !== h_pc || s_iv !== 1'b0) begin
        errors++; $display("FAIL stall_hold k=%0d: got v=%b inst=%h pc=%h iv=%b want 1 %h %h 0", k, s_v, s_i, s_pc, s_iv, h_i, h_pc);
      end
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (dlv !== 1'b1 || s_pc !== 32'hbfc0_0000 || s_i !== mem(32'hbfc0_0000)) begin
      errors++; $display("FAIL stall_release: got dlv=%b pc=%h inst=%h want 1 bfc00000 %h", dlv, s_pc, s_i, mem(32'hbfc0_0000));
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (s_v !== 1'b0) begin errors++; $display("FAIL stall_single k=%0d: got inst_valid=%b want 0", k, s_v); end
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] fa, fp, fi;
    bit found, got_a, got_d;
    ok_gap = 0; data_lat = 2; rnd_bus = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b0, 1'b0, '0);
      found = acc && s_ia == 32'hbfc0_0004;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rwait_reach: got no request to bfc00004 want one"); end
    cycle(1'b0, 1'b1, 32'h8000_0180);
    got_a = 1'b0; got_d = 1'b0; fa = '0; fp = '0; fi = '0;
    for (int k = 0; k < 30 && !got_d; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (acc && !got_a) begin got_a = 1'b1; fa = s_ia; end
      if (dlv) begin got_d = 1'b1; fp = s_pc; fi = s_i; end
    end
    checks++;
    if (!got_a || fa !== 32'h8000_0180) begin errors++; $display("FAIL rwait_req: got %b/%h want 1/80000180", got_a, fa); end
    checks++;
    if (!got_d || fp !== 32'h8000_0180 || fi !== mem(32'h8000_0180)) begin
      errors++; $display("FAIL rwait_inst: got %b pc=%h inst=%h want 1 80000180 %h", got_d, fp, fi, mem(32'h8000_0180));
    end
  endtask

  task automatic test_redirect_req();
    logic [31:0] fa, fp;
    bit got_a, got_d;
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    do_reset();
    ok_delay = 3;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, k == 0, 32'h8000_1000);
      checks++;
      if (s_iv !== 1'b1 || s_ia !== 32'hbfc0_0000 || acc !== 1'b0) begin
        errors++; $display("FAIL rreq_stable k=%0d: got iv=%b addr=%h want 1 bfc00000", k, s_iv, s_ia);
      end
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (acc !== 1'b1 || s_ia !== 32'hbfc0_0000) begin errors++; $display("FAIL rreq_old: got acc=%b addr=%h want 1 bfc00000", acc, s_ia); end
    got_a = 1'b0; got_d = 1'b0; fa = '0; fp = '0;
    for (int k = 0; k < 20 && !got_d; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (acc && !got_a) begin got_a = 1'b1; fa = s_ia; end
      if (dlv) begin got_d = 1'b1; fp = s_pc; end
    end
    checks++;
    if (!got_a || fa !== 32'h8000_1000) begin errors++; $display("FAIL rreq_next: got %b/%h want 1/80001000", got_a, fa); end
    checks++;
    if (!got_d || fp !== 32'h8000_1000) begin errors++; $display("FAIL rreq_inst: got %b/%h want 1/80001000", got_d, fp); end
  endtask

  task automatic test_adel();
    int n;
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    do_reset();
    n = 0;
    do begin cycle(1'b1, 1'b0, '0); n++; end while (!s_v && n < 10);
    cycle(1'b1, 1'b1, 32'h8000_0002);
    cycle(1'b1, 1'b0, '0);
    checks++;
    if (s_iv !== 1'b0 || s_v !== 1'b0) begin errors++; $display("FAIL adel_noreq: got iv=%b v=%b want 0 0", s_iv, s_v); end
    cycle(1'b1, 1'b0, '0);
    checks++;
    if (s_v !== 1'b1 || s_adel !== 1'b1 || s_pc !== 32'h8000_0002 || s_i !== 32'h0 || s_iv !== 1'b0) begin
      errors++; $display("FAIL adel_entry: got v=%b adel=%b pc=%h inst=%h iv=%b want 1 1 80000002 0 0", s_v, s_adel, s_pc, s_i, s_iv);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] p0, p1, i1;
    int nd;
    ok_gap = 0; data_lat = 0; rnd_bus = 1'b0;
    do_reset();
    cycle(1'b0, 1'b1, 32'hffff_fffc);
    nd = 0; p0 = '0; p1 = '1; i1 = '0;
    for (int k = 0; k < 30 && nd < 2; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (dlv && nd == 0) p0 = s_pc;
      if (dlv && nd == 1) begin p1 = s_pc; i1 = s_i; end
      if (dlv) nd++;
    end
    checks++;
    if (nd != 2 || p0 !== 32'hffff_fffc || p1 !== 32'h0 || i1 !== mem(32'h0)) begin
      errors++; $display("FAIL wrap: got n=%0d pc0=%h pc1=%h inst1=%h want 2 fffffffc 00000000 %h", nd, p0, p1, i1, mem(32'h0));
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] fp, fi;
    bit got_d;
    ok_gap = 0; data_lat = 3; rnd_bus = 1'b0;
    do_reset();
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL rstw_accept: got acc=%b want 1", acc); end
    #2 resetn = 1'b0; busy = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    checks++;
    if (ireq_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_in_reset: got iv=%b v=%b want 0 0", ireq_valid, inst_valid);
    end
    #1 resetn = 1'b1;
    @(negedge clk);
    data_ok = 1'b1; rdata = 32'hdead_beef;
    @(posedge clk);
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (s_v !== 1'b0 || s_iv !== 1'b1 || s_ia !== 32'hbfc0_0000) begin
      errors++; $display("FAIL rstw_stray: got v=%b iv=%b addr=%h want 0 1 bfc00000", s_v, s_iv, s_ia);
    end
    got_d = 1'b0; fp = '0; fi = '0;
    for (int k = 0; k < 20 && !got_d; k++) begin
      cycle(1'b0, 1'b0, '0);
      if (dlv) begin got_d = 1'b1; fp = s_pc; fi = s_i; end
    end
    checks++;
    if (!got_d || fp !== 32'hbfc0_0000 || fi !== mem(32'hbfc0_0000)) begin
      errors++; $display("FAIL rstw_first: got %b pc=%h inst=%h want 1 bfc00000 %h", got_d, fp, fi, mem(32'hbfc0_0000));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, rp;
    logic st, rv;
    bit prev_pend;
    int ndlv;
    ok_gap = 0; rnd_bus = 1'b1;
    do_reset();
    exp_pc = 32'hbfc0_0000; prev_pend = 1'b0; prev_addr = '0; ndlv = 0;
    for (int k = 0; k < 600; k++) begin
      st = $urandom_range(0, 9) < 3;
      rv = $urandom_range(0, 19) == 0;
      case ($urandom_range(0, 3))
        0: rp = $urandom & 32'hffff_fffc;
        1: rp = 32'h8000_0180;
        2: rp = 32'hffff_fff8;
        default: rp = 32'h0000_0ffc;
      endcase
      cycle(st, rv, rp);
      if (prev_pend) begin
        checks++;
        if (s_iv !== 1'b1 || s_ia !== prev_addr) begin
          errors++; $display("FAIL rand_addr_stable k=%0d: got iv=%b addr=%h want 1 %h", k, s_iv, s_ia, prev_addr);
        end
      end
      prev_pend = s_iv && !acc; prev_addr = s_ia;
      if (dlv) begin
        checks++;
        if (s_pc !== exp_pc || s_i !== mem(exp_pc) || s_adel !== 1'b0) begin
          errors++; $display("FAIL rand_inst k=%0d: got pc=%h inst=%h adel=%b want %h %h 0", k, s_pc, s_i, s_adel, exp_pc, mem(exp_pc));
        end
        exp_pc += 32'd4; ndlv++;
      end
      if (rv) exp_pc = rp;
    end
    checks++;
    if (ndlv < 20) begin errors++; $display("FAIL rand_progress: got %0d deliveries want at least 20", ndlv); end
    rnd_bus = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_adel();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
